// File: rtl/recompose3.sv
// recompose3: recovers ANGLE = asin(P^2) on the return path of the decomposition chain.
// A shift-add squarer feeds a double-iteration arcsine CORDIC; one result per 2*width+2 cycles.
module recompose3 #(
  parameter int width = 16,
  parameter int guard = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  input  logic [width-1:0] P,
  output logic             READY,
  output logic             OUT_VALID,
  output logic [width-1:0] ANGLE
);

  localparam int F    = width + guard;
  localparam int CW   = F + 3;
  localparam int CNTW = $clog2(width);

  localparam logic signed [CW-1:0] ONE  = {2'b00, 1'b1, {F{1'b0}}};
  localparam logic signed [CW-1:0] HALF = {{(CW-guard){1'b0}}, 1'b1, {(guard-1){1'b0}}};

  // atan(2^-i) in quarter-turn units, tabulated at 20 fractional bits and rescaled to F.
  localparam int ATAN20 [16] = '{524288, 309505, 163534, 83012, 41667, 20854, 10430, 5215,
                                 2608, 1304, 652, 326, 163, 81, 41, 20};

  typedef enum logic [1:0] {IDLE, SQR, ASIN, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [CNTW-1:0]         cnt_reg;
  logic [2*width-1:0]      prod_reg;
  logic [width-1:0]        mcand_reg;
  logic                    s_zero_reg;
  logic signed [CW-1:0]    x_reg, y_reg, z_reg, t_reg;
  logic [width-1:0]        angle_reg;

  logic                    last_iter;
  logic [width:0]          upper_sum;
  logic [2*width-1:0]      prod_next;
  logic [width-1:0]        s_next;
  logic signed [CW-1:0]    atan_tab [width];
  logic signed [CW-1:0]    atan_cur;
  logic                    d_pos;
  logic signed [CW-1:0]    x_sh, y_sh, x_sq, y_sq, t_sq;
  logic signed [CW-1:0]    x_next, y_next, z_next, t_next;
  logic signed [CW-1:0]    z_rnd;
  logic [width-1:0]        angle_next;

  generate
    for (genvar gi = 0; gi < width; gi++) begin : g_atan
      localparam int BASE = (gi < 16) ? ATAN20[gi] : (ATAN20[15] >> (gi - 15));
      if (F >= 20) begin : g_up
        assign atan_tab[gi] = CW'(BASE) <<< (F - 20);
      end else begin : g_dn
        assign atan_tab[gi] = CW'(BASE) >>> (20 - F);
      end
    end
  endgenerate

  assign last_iter = (cnt_reg == CNTW'(width - 1));

  // Squarer: multiplier bits leave through the LSB while partial sums enter at the top.
  always_comb begin
    upper_sum = {1'b0, prod_reg[2*width-1:width]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
    prod_next = {upper_sum, prod_reg[width-1:1]};
    s_next    = prod_next[2*width-1:width];
  end

  always_comb begin
    atan_cur = atan_tab[cnt_reg];
    d_pos    = (y_reg < t_reg);
    x_sh     = (cnt_reg == '0) ? (x_reg <<< 1) : (x_reg >>> (cnt_reg - 1'b1));
    y_sh     = (cnt_reg == '0) ? (y_reg <<< 1) : (y_reg >>> (cnt_reg - 1'b1));
    x_sq     = x_reg >>> {cnt_reg, 1'b0};
    y_sq     = y_reg >>> {cnt_reg, 1'b0};
    t_sq     = t_reg >>> {cnt_reg, 1'b0};
    if (d_pos) begin
      x_next = x_reg - y_sh - x_sq;
      y_next = y_reg + x_sh - y_sq;
      z_next = z_reg + (atan_cur <<< 1);
    end else begin
      x_next = x_reg + y_sh - x_sq;
      y_next = y_reg - x_sh - y_sq;
      z_next = z_reg - (atan_cur <<< 1);
    end
    t_next = t_reg + t_sq;
  end

  // Round away the guard bits, then clamp into the unsigned output range.
  always_comb begin
    z_rnd = (z_next + HALF) >>> guard;
    if (z_rnd[CW-1])
      angle_next = '0;
    else if (|z_rnd[CW-2:width])
      angle_next = '1;
    else
      angle_next = z_rnd[width-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (IN_VALID) state_next = SQR;
      SQR:     if (last_iter) state_next = ASIN;
      ASIN:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    READY     = (state_reg == IDLE);
    OUT_VALID = (state_reg == DONE);
    ANGLE     = angle_reg;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_reg    <= '0;
      prod_reg   <= '0;
      mcand_reg  <= '0;
      s_zero_reg <= 1'b0;
      x_reg      <= '0;
      y_reg      <= '0;
      z_reg      <= '0;
      t_reg      <= '0;
      angle_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (IN_VALID) begin
            prod_reg  <= {{width{1'b0}}, P};
            mcand_reg <= P;
            cnt_reg   <= '0;
          end
        end
        SQR: begin
          prod_reg <= prod_next;
          cnt_reg  <= cnt_reg + 1'b1;
          if (last_iter) begin
            cnt_reg    <= '0;
            s_zero_reg <= (s_next == '0);
            x_reg      <= ONE;
            y_reg      <= '0;
            z_reg      <= '0;
            t_reg      <= {3'b000, s_next, {guard{1'b0}}};
          end
        end
        ASIN: begin
          x_reg   <= x_next;
          y_reg   <= y_next;
          z_reg   <= z_next;
          t_reg   <= t_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_iter) begin
            cnt_reg   <= '0;
            angle_reg <= s_zero_reg ? '0 : angle_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_recompose3.sv
// Scoreboard bench for recompose3: an arcsine reference model predicts each result and
// its completion cycle; a negedge monitor checks READY, OUT_VALID timing and ANGLE.
module tb_recompose3;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic         IN_VALID;
  logic [W-1:0] P;
  logic         READY;
  logic         OUT_VALID;
  logic [W-1:0] ANGLE;

  recompose3 #(.width(W), .guard(4)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .P(P),
    .READY(READY), .OUT_VALID(OUT_VALID), .ANGLE(ANGLE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int due;
    int p;
    int s;
    int expv;
    int tol;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   busy = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input bit ok, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
  endtask

  function automatic exp_t model(input int p, input int acc);
    exp_t e;
    real  r;
    e.p   = p;
    e.due = acc + 2 * W;
    e.s   = int'((longint'(p) * longint'(p)) >> W);
    if (e.s == 0) begin
      e.expv = 0;
      e.tol  = 0;
    end else begin
      r = $asin(real'(e.s) / 65536.0) * 65536.0 / (3.14159265358979 / 2.0);
      e.expv = int'($floor(r + 0.5));
      if (e.expv > 65535) e.expv = 65535;
      e.tol = (e.s * 100 <= 98 * 65536) ? 4 : 64;
    end
    return e;
  endfunction

  // Reference of the handshake: accept when idle, busy for 2*W+1 cycles afterwards.
  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      sb.delete();
      busy = 0;
    end else if (busy == 0 && IN_VALID) begin
      sb.push_back(model(int'(P), cyc));
      busy = 2 * W + 1;
    end else if (busy > 0) begin
      busy--;
    end
  end

  always @(negedge CLK) begin
    bit   exp_ov;
    exp_t e;
    int   diff;
    chk("ready", READY === (busy == 0), int'(READY), int'(busy == 0));
    exp_ov = (sb.size() > 0) && (sb[0].due == cyc);
    chk("out_valid", OUT_VALID === exp_ov, int'(OUT_VALID), int'(exp_ov));
    if (exp_ov) begin
      e = sb.pop_front();
      if (OUT_VALID === 1'b1) begin
        diff = int'(ANGLE) - e.expv;
        if (diff < 0) diff = -diff;
        chk($sformatf("angle P=%04h S=%04h", e.p, e.s), !$isunknown(ANGLE) && diff <= e.tol,
            int'(ANGLE), e.expv);
        $display("txn P=%04h S=%04h angle=%0d model=%0d tol=%0d", e.p, e.s, ANGLE, e.expv, e.tol);
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while ((busy != 0 || sb.size() != 0) && g < 200) begin
      @(posedge CLK);
      #1;
      g++;
    end
    if (g >= 200) chk("idle_timeout", 1'b0, busy, 0);
  endtask

  task automatic issue(input logic [W-1:0] p);
    int g = 0;
    while (busy != 0 && g < 200) begin
      @(posedge CLK);
      #1;
      g++;
    end
    if (g >= 200) chk("ready_timeout", 1'b0, busy, 0);
    IN_VALID = 1'b1;
    P        = p;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    P        = W'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RST      = 1'b1;
    IN_VALID = 1'b0;
    P        = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_angle", ANGLE === '0, int'(ANGLE), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    issue(16'h0000);
    wait_idle();
    issue(16'h8000);
    wait_idle();
    issue(16'hB505);
    wait_idle();
    issue(16'hFFFF);
    wait_idle();

    // Held-high IN_VALID with P changing every cycle; busy-time inputs must be ignored.
    IN_VALID = 1'b1;
    repeat (34 * 5 + 3) begin
      P = W'($urandom);
      @(posedge CLK);
      #1;
    end
    IN_VALID = 1'b0;
    wait_idle();

    // Reset sampled on the edge of cycle 20 of an operation.
    issue(16'hC3A5);
    repeat (19) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("abort_angle", ANGLE === '0, int'(ANGLE), 0);
    chk("abort_ready", READY === 1'b1, int'(READY), 1);
    issue(16'h9E37);
    wait_idle();

    // Reset coinciding with IN_VALID drops the input.
    IN_VALID = 1'b1;
    P        = 16'h7777;
    RST      = 1'b1;
    @(posedge CLK);
    #1;
    RST      = 1'b0;
    IN_VALID = 1'b0;
    wait_idle();

    repeat (30) begin
      repeat ($urandom_range(0, 5)) begin
        @(posedge CLK);
        #1;
      end
      if ($urandom_range(0, 3) == 0) issue(W'($urandom_range(0, 300)));
      else issue(W'($urandom));
    end
    wait_idle();
    repeat (3) @(posedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
